// File: rtl/uart_mmio_tx.sv
// uart_mmio_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and a status register
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   MemWrite   gated store strobe
//   Addr       data address
//   WriteData  store data; [7:0] is the TX byte, [3] clears overflow at STATUS_ADDR
//   ReadData   status word at STATUS_ADDR, otherwise zero (combinational)
//   tx         serial line, idle high, registered
//   fifo_full  FIFO holds FIFO_DEPTH bytes
//   tx_busy    a frame is in progress
module uart_mmio_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] TX_ADDR      = 32'h0000_0400,
    parameter logic [31:0] STATUS_ADDR  = 32'h0000_0404
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        fifo_full,
    output logic        tx_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic full, empty, tx_sel, push, pop, baud_done;
    logic unused_wdata;

    assign unused_wdata = ^WriteData[31:8];
    assign full      = count_q == DEPTH;
    assign empty     = count_q == '0;
    assign tx_sel    = MemWrite && Addr == TX_ADDR;
    assign push      = tx_sel && !full;
    assign pop       = state_q == IDLE && !empty;
    assign baud_done = baud_q == BAUD_MAX;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (pop) begin
                state_d = START;
                baud_d  = '0;
                shift_d = mem_q[rd_ptr_q];
            end
            START: if (baud_done) begin
                state_d = DATA;
                baud_d  = '0;
                idx_d   = '0;
            end else begin
                baud_d = baud_q + BW'(1);
            end
            DATA: if (baud_done) begin
                baud_d  = '0;
                shift_d = {1'b0, shift_q[7:1]};
                idx_d   = idx_q + 3'd1;
                state_d = idx_q == 3'd7 ? STOP : DATA;
            end else begin
                baud_d = baud_q + BW'(1);
            end
            STOP: if (baud_done) begin
                state_d = IDLE;
                baud_d  = '0;
            end else begin
                baud_d = baud_q + BW'(1);
            end
            default: state_d = IDLE;
        endcase
        // tx is registered from the next state so the line moves on the same edge as the FSM
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        // a store to a full FIFO flags overflow even if a pop frees a slot on that edge
        ovf_d    = (tx_sel && full) ? 1'b1 :
                   (MemWrite && Addr == STATUS_ADDR && WriteData[3]) ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= WriteData[7:0];
    end

    assign tx        = tx_q;
    assign tx_busy   = state_q != IDLE;
    assign fifo_full = full;
    assign ReadData  = Addr == STATUS_ADDR ?
                       {19'b0, 8'(count_q), 1'b0, ovf_q, tx_busy, empty, full} : 32'h0;
endmodule

// File: tb/tb_uart_mmio_tx.sv
// tb_uart_mmio_tx: directed and randomized checks of uart_mmio_tx against a serial-line reference
module tb_uart_mmio_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] TXA = 32'h0000_0400;
    localparam logic [31:0] STA = 32'h0000_0404;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr = STA;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        tx, fifo_full, tx_busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit mon_en = 1'b1;

    always #5 clk = ~clk;

    uart_mmio_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH),
        .TX_ADDR(TXA),
        .STATUS_ADDR(STA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .Addr(Addr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .tx(tx),
        .fifo_full(fifo_full),
        .tx_busy(tx_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ideal 8N1 line level j cycles after the frame starts.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        return j < CPB ? 1'b0 : j < 9 * CPB ? b[(j - CPB) / CPB] : 1'b1;
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        Addr = a;
        WriteData = d;
        @(negedge clk);
        MemWrite = 1'b0;
        Addr = STA;
        WriteData = 32'h0;
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(ReadData[1] && !tx_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(n < 2000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic cmp_rx(input string tag);
        chk({tag, "_rx_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({tag, "_rx_byte"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    // Serial receiver: samples mid-bit and collects decoded bytes.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset && mon_en && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                chk("mon_start_bit", tx, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                chk("mon_stop_bit", tx, 32'd1);
                if (mon_en) rx_q.push_back(b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, base;
        int i, guard;
        bit low_seen;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 32'd1);
        chk("rst_busy", tx_busy, 32'd0);
        chk("rst_full", fifo_full, 32'd0);
        chk("rst_status", ReadData, 32'h2);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single frame, exact waveform; upper data bits ignored
        MemWrite = 1'b1;
        Addr = TXA;
        WriteData = 32'hABCD_EF55;
        @(negedge clk);
        chk("t1_rd_nonstatus", ReadData, 32'h0);
        chk("t1_prepop_tx", tx, 32'd1);
        MemWrite = 1'b0;
        Addr = STA;
        #1;
        chk("t1_count1", ReadData[12:5], 32'd1);
        @(negedge clk);
        for (int j = 0; j < 10 * CPB; j++) begin
            chk("t1_tx", tx, frame_bit(8'h55, j));
            chk("t1_busy", tx_busy, 32'd1);
            @(negedge clk);
        end
        chk("t1_busy_end", tx_busy, 32'd0);
        chk("t1_empty", ReadData[1], 32'd1);
        exp_q.push_back(8'h55);
        repeat (2) @(negedge clk);
        cmp_rx("t1");

        // back-to-back frames with a 1-cycle gap
        MemWrite = 1'b1;
        Addr = TXA;
        WriteData = 32'h41;
        @(negedge clk);
        WriteData = 32'h42;
        @(negedge clk);
        MemWrite = 1'b0;
        Addr = STA;
        #1;
        chk("t2_count_pushpop", ReadData[12:5], 32'd1);
        for (int j = 0; j < 20 * CPB + 1; j++) begin
            chk("t2_tx", tx, j < 10 * CPB ? frame_bit(8'h41, j) :
                             j == 10 * CPB ? 1'b1 : frame_bit(8'h42, j - 10 * CPB - 1));
            @(negedge clk);
        end
        chk("t2_busy_end", tx_busy, 32'd0);
        chk("t2_empty", ReadData[1], 32'd1);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        repeat (2) @(negedge clk);
        cmp_rx("t2");

        // overflow while the FSM is busy
        v = $urandom;
        exp_q.push_back(v[7:0]);
        store(TXA, v);
        for (int k = 0; k <= DEPTH; k++) begin
            MemWrite = 1'b1;
            Addr = TXA;
            WriteData = $urandom;
            if (k < DEPTH) exp_q.push_back(WriteData[7:0]);
            @(negedge clk);
            chk("t3_full_flag", fifo_full, 32'(k + 1 >= DEPTH));
        end
        MemWrite = 1'b0;
        Addr = STA;
        #1;
        chk("t3_count", ReadData[12:5], DEPTH);
        chk("t3_status_full", ReadData[0], 32'd1);
        chk("t3_ovf_set", ReadData[3], 32'd1);
        chk("t3_busy", tx_busy, 32'd1);
        store(STA, 32'h7);
        chk("t3_ovf_kept", ReadData[3], 32'd1);
        store(STA, 32'h8);
        chk("t3_ovf_clr", ReadData[3], 32'd0);
        drain("t3");
        cmp_rx("t3");

        // non-pushing accesses
        Addr = TXA;
        WriteData = 32'h11;
        @(negedge clk);
        MemWrite = 1'b1;
        Addr = 32'h408;
        WriteData = 32'h22;
        #1;
        chk("t4_rd_other", ReadData, 32'h0);
        @(negedge clk);
        MemWrite = 1'b0;
        Addr = STA;
        #1;
        chk("t4_count", ReadData[12:5], 32'd0);
        chk("t4_empty", ReadData[1], 32'd1);
        repeat (5) @(negedge clk);
        chk("t4_tx", tx, 32'd1);
        chk("t4_busy", tx_busy, 32'd0);

        // reset during DATA bit 3 aborts the frame and empties the FIFO
        mon_en = 1'b0;
        store(TXA, 32'hA5);
        store(TXA, 32'h3C);
        repeat (4 * CPB + 1) @(negedge clk);
        chk("t5_prereset_tx", tx, frame_bit(8'hA5, 4 * CPB + 1));
        chk("t5_prereset_count", ReadData[12:5], 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_tx", tx, 32'd1);
        chk("t5_busy", tx_busy, 32'd0);
        chk("t5_count", ReadData[12:5], 32'd0);
        @(negedge clk);
        reset = 1'b1;
        low_seen = 1'b0;
        for (int j = 0; j < 15 * CPB; j++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) low_seen = 1'b1;
        end
        chk("t5_no_frame", low_seen, 32'd0);
        mon_en = 1'b1;

        // random-paced stream across pointer wrap
        base = $urandom;
        i = 0;
        guard = 0;
        while (i < 3 * DEPTH && guard < 5000) begin
            if (!fifo_full && $urandom_range(0, 3) != 0) begin
                v = base + 32'(i);
                MemWrite = 1'b1;
                Addr = TXA;
                WriteData = v;
                exp_q.push_back(v[7:0]);
                i++;
            end else begin
                MemWrite = 1'b0;
                Addr = STA;
            end
            @(negedge clk);
            guard++;
        end
        MemWrite = 1'b0;
        Addr = STA;
        #1;
        chk("t6_push_timeout", 32'(guard < 5000), 32'd1);
        drain("t6");
        chk("t6_ovf", ReadData[3], 32'd0);
        cmp_rx("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
